// File: rtl/led_arbiter.sv
// Front-panel LED arbiter: strict-priority ownership with a minimum display hold,
// plus a walking/all-on lamp test after reset or on command.
module led_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 10019750,
    parameter int STEP_CYCLES = 2504937,
    parameter int CNT_WIDTH   = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [16*N_REQ-1:0]  data_i,
    input  logic [15:0]          default_i,
    input  logic                 lamp_test_i,
    output logic [15:0]          led_o,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 lamp_busy_o
);

    typedef enum logic [1:0] {
        LAMP_WALK,
        LAMP_ALL,
        IDLE,
        OWNED
    } state_t;

    localparam logic [CNT_WIDTH-1:0] STEP_LAST = CNT_WIDTH'(STEP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);

    state_t                 state_q;
    logic [3:0]             pos_q;
    logic [CNT_WIDTH-1:0]   step_q;
    logic [CNT_WIDTH-1:0]   hold_q;
    logic [15:0]            led_q;
    logic [N_REQ-1:0]       grant_q;
    logic                   busy_q;

    logic [N_REQ-1:0]       win_grant;
    logic [15:0]            win_data;
    logic                   owner_req;
    logic                   lower_req;
    logic                   hold_done;

    // Lowest-index requester wins; scanning downward leaves it as the last assignment.
    always_comb begin
        win_grant = '0;
        win_data  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                win_grant    = '0;
                win_grant[k] = 1'b1;
                win_data     = data_i[16*k +: 16];
            end
        end
    end

    assign owner_req = |(req_i & grant_q);
    // grant_q is one-hot in OWNED, so grant_q - 1 masks every higher-priority source.
    assign lower_req = |(req_i & (grant_q - N_REQ'(1)));
    assign hold_done = (hold_q == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LAMP_WALK;
            pos_q   <= '0;
            step_q  <= '0;
            hold_q  <= '0;
            led_q   <= 16'h0001;
            grant_q <= '0;
            busy_q  <= 1'b1;
        end else if (lamp_test_i && (state_q == IDLE || state_q == OWNED)) begin
            state_q <= LAMP_WALK;
            pos_q   <= '0;
            step_q  <= '0;
            hold_q  <= '0;
            led_q   <= 16'h0001;
            grant_q <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                LAMP_WALK: begin
                    if (step_q == STEP_LAST) begin
                        step_q <= '0;
                        if (pos_q == 4'd15) begin
                            state_q <= LAMP_ALL;
                            led_q   <= 16'hFFFF;
                        end else begin
                            pos_q <= pos_q + 4'd1;
                            led_q <= {led_q[14:0], 1'b0};
                        end
                    end else begin
                        step_q <= step_q + CNT_WIDTH'(1);
                    end
                end
                LAMP_ALL: begin
                    if (step_q == STEP_LAST) begin
                        step_q  <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        led_q   <= default_i;
                    end else begin
                        step_q <= step_q + CNT_WIDTH'(1);
                    end
                end
                IDLE: begin
                    if (|req_i) begin
                        state_q <= OWNED;
                        grant_q <= win_grant;
                        led_q   <= win_data;
                        hold_q  <= HOLD_LOAD;
                    end else begin
                        led_q <= default_i;
                    end
                end
                OWNED: begin
                    if (lower_req || (hold_done && !owner_req && |req_i)) begin
                        grant_q <= win_grant;
                        led_q   <= win_data;
                        hold_q  <= HOLD_LOAD;
                    end else if (owner_req || !hold_done) begin
                        // With no lower request pending, the winner is the owner itself.
                        if (owner_req) led_q <= win_data;
                        if (!hold_done) hold_q <= hold_q - CNT_WIDTH'(1);
                    end else begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        led_q   <= default_i;
                    end
                end
            endcase
        end
    end

    assign led_o       = led_q;
    assign grant_o     = grant_q;
    assign lamp_busy_o = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: each driven cycle queues the expected outputs
// after the next edge; a monitor pops and compares them just after that edge.
module tb_led_arbiter;

    localparam int N_REQ = 4;

    logic                clock;
    logic                reset;
    logic [N_REQ-1:0]    req_i;
    logic [16*N_REQ-1:0] data_i;
    logic [15:0]         default_i;
    logic                lamp_test_i;
    logic [15:0]         led_o;
    logic [N_REQ-1:0]    grant_o;
    logic                lamp_busy_o;

    typedef struct {
        string       tag;
        logic [15:0] led;
        logic [3:0]  grant;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    led_arbiter #(
        .N_REQ       (N_REQ),
        .HOLD_CYCLES (8),
        .STEP_CYCLES (4),
        .CNT_WIDTH   (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_i       (req_i),
        .data_i      (data_i),
        .default_i   (default_i),
        .lamp_test_i (lamp_test_i),
        .led_o       (led_o),
        .grant_o     (grant_o),
        .lamp_busy_o (lamp_busy_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Lamp-test LED pattern j edges after the test starts (4-cycle steps).
    function automatic logic [15:0] lamp_led(input int j);
        logic [15:0] one;
        one = 16'h0001;
        return (j < 64) ? (one << (j / 4)) : 16'hFFFF;
    endfunction

    // Drive inputs now (at a falling edge), queue what must appear after the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] req, input logic lamp,
                       input logic [15:0] e_led, input logic [3:0] e_grant, input logic e_busy);
        exp_t e;
        req_i       = req;
        lamp_test_i = lamp;
        e.tag   = tag;
        e.led   = e_led;
        e.grant = e_grant;
        e.busy  = e_busy;
        sb.push_back(e);
        @(negedge clock);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, ".led"},   32'(led_o),       32'(e.led));
            check({e.tag, ".grant"}, 32'(grant_o),     32'(e.grant));
            check({e.tag, ".busy"},  32'(lamp_busy_o), 32'(e.busy));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        req_i       = '0;
        lamp_test_i = 1'b0;
        default_i   = 16'hA5A5;
        data_i      = {16'hD333, 16'hC222, 16'h00F0, 16'hB000};

        repeat (3) @(negedge clock);
        check("rst.led",   32'(led_o),       32'h0001);
        check("rst.grant", 32'(grant_o),     32'h0);
        check("rst.busy",  32'(lamp_busy_o), 32'h1);
        reset = 1'b0;

        // Lamp test after reset: 16 walking steps plus all-on, 68 cycles in total.
        for (int i = 1; i < 68; i++) cyc("lamp", 4'b0000, 1'b0, lamp_led(i), 4'b0000, 1'b1);
        cyc("lamp_end", 4'b0000, 1'b0, 16'hA5A5, 4'b0000, 1'b0);

        // Priority tie: source 1 beats source 3.
        cyc("tie", 4'b1010, 1'b0, 16'h00F0, 4'b0010, 1'b0);
        // Owner drops before hold expiry: LEDs freeze, then IDLE at g+8.
        repeat (7) cyc("freeze1", 4'b0000, 1'b0, 16'h00F0, 4'b0010, 1'b0);
        cyc("to_idle", 4'b0000, 1'b0, 16'hA5A5, 4'b0000, 1'b0);

        // Hold enforcement: source 2 granted, drops 2 cycles later while source 3 requests.
        cyc("grant2", 4'b0100, 1'b0, 16'hC222, 4'b0100, 1'b0);
        cyc("own2",   4'b0100, 1'b0, 16'hC222, 4'b0100, 1'b0);
        repeat (6) cyc("hold2", 4'b1000, 1'b0, 16'hC222, 4'b0100, 1'b0);
        cyc("grant3", 4'b1000, 1'b0, 16'hD333, 4'b1000, 1'b0);

        // Preemption with 6 hold cycles left.
        cyc("own3",    4'b1000, 1'b0, 16'hD333, 4'b1000, 1'b0);
        cyc("preempt", 4'b1001, 1'b0, 16'hB000, 4'b0001, 1'b0);

        // Source 0 drops; source 1 waits out the hold, then takes over.
        repeat (7) cyc("hold0", 4'b0010, 1'b0, 16'hB000, 4'b0001, 1'b0);
        cyc("grant1", 4'b0010, 1'b0, 16'h00F0, 4'b0010, 1'b0);

        // Lamp abort while source 1 owns; a second pulse mid-test must not restart it.
        cyc("abort", 4'b0010, 1'b1, 16'h0001, 4'b0000, 1'b1);
        for (int j = 1; j < 68; j++)
            cyc("relamp", 4'b0010, (j == 10), lamp_led(j), 4'b0000, 1'b1);
        cyc("relamp_end", 4'b0010, 1'b0, 16'hA5A5, 4'b0000, 1'b0);
        cyc("regrant1",   4'b0010, 1'b0, 16'h00F0, 4'b0010, 1'b0);

        // Asynchronous reset between edges while source 1 owns.
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("arst.led",   32'(led_o),       32'h0001);
        check("arst.grant", 32'(grant_o),     32'h0);
        check("arst.busy",  32'(lamp_busy_o), 32'h1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int j = 1; j <= 5; j++) cyc("post_rst", 4'b0010, 1'b0, lamp_led(j), 4'b0000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
